// File: rtl/aes_cpu_pkg.sv
// Shared AES control-unit definitions: opcode encoding, round-sequencer states
// and the state-to-opcode mapping used by the sequencer.
package aes_cpu_pkg;

    localparam int OPW = 4;

    typedef enum logic [3:0] {
        END    = 4'd0,
        SETC   = 4'd1,
        DEC    = 4'd2,
        BNZ    = 4'd3,
        MATSET = 4'd4,
        MATXOR = 4'd5,
        ROTSB  = 4'd6,
        XFL    = 4'd7,
        XNC    = 4'd8,
        MSHL   = 4'd9,
        SUB    = 4'd10,
        SHR    = 4'd11,
        MIX    = 4'd12
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ARK0, S_SETC, S_KROT, S_KXFL, S_KXNC,
        S_SUB, S_SHR, S_MIX, S_ARK, S_DEC, S_FIN
    } seq_state_t;

    // Idle and the final step both present END; only FIN marks it valid.
    function automatic op_t state_op(input seq_state_t s);
        case (s)
            S_LOAD:  return MATSET;
            S_ARK0:  return MATXOR;
            S_SETC:  return SETC;
            S_KROT:  return ROTSB;
            S_KXFL:  return XFL;
            S_KXNC:  return XNC;
            S_SUB:   return SUB;
            S_SHR:   return SHR;
            S_MIX:   return MIX;
            S_ARK:   return MATXOR;
            S_DEC:   return DEC;
            default: return END;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// On-chip AES-128 round scheduler: walks the load / key-add / round step table
// and hands one opcode at a time to the control unit over a valid/ready handshake.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int OPW        = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           op_ready,
    output logic           op_valid,
    output logic [OPW-1:0] op_code,
    output logic [3:0]     round_idx,
    output logic           busy,
    output logic           done
);
    import aes_cpu_pkg::*;

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic [3:0] r_round;
    logic [3:0] w_round_next;
    logic       r_valid;
    op_t        r_op;
    logic       r_done;
    logic       w_done_next;
    logic       w_xfer;
    logic       w_last;

    assign w_xfer = r_valid && op_ready;
    assign w_last = (r_round == 4'(NUM_ROUNDS));

    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        w_done_next  = 1'b0;
        if (r_state == S_IDLE) begin
            w_round_next = 4'd0;
            if (start) begin
                w_state_next = S_LOAD;
            end
        end else if (abort) begin
            // Cancel wins over a transfer landing in the same cycle.
            w_state_next = S_IDLE;
            w_round_next = 4'd0;
        end else if (w_xfer) begin
            case (r_state)
                S_LOAD: w_state_next = S_ARK0;
                S_ARK0: w_state_next = S_SETC;
                S_SETC: begin
                    w_state_next = S_KROT;
                    w_round_next = 4'd1;
                end
                S_KROT: w_state_next = S_KXFL;
                S_KXFL: w_state_next = S_KXNC;
                S_KXNC: w_state_next = S_SUB;
                S_SUB:  w_state_next = S_SHR;
                S_SHR:  w_state_next = w_last ? S_ARK : S_MIX;
                S_MIX:  w_state_next = S_ARK;
                S_ARK:  w_state_next = S_DEC;
                S_DEC: begin
                    if (w_last) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_state_next = S_KROT;
                        w_round_next = r_round + 4'd1;
                    end
                end
                S_FIN: begin
                    w_state_next = S_IDLE;
                    w_round_next = 4'd0;
                    w_done_next  = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_round_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_op    <= END;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_valid <= (w_state_next != S_IDLE);
            r_op    <= state_op(w_state_next);
            r_done  <= w_done_next;
        end
    end

    assign op_valid  = r_valid;
    assign op_code   = OPW'(r_op);
    assign round_idx = r_round;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
